// File: rtl/ibex_instr_realigner.sv
// ---------------------------------------------------------------------------
// ibex_instr_realigner
//
// Purpose:
//   Realignment buffer between the instruction fetch interface and the
//   compressed decoder. Word-aligned 32-bit fetch words are stored in a small
//   FIFO. One instruction (16-bit compressed or 32-bit) is presented per
//   handshake, together with its PC. A 32-bit instruction that starts in the
//   upper half of a word straddles into the next stored word.
//
// Optional feature (macro IBEX_REALIGN_BYPASS_EN):
//   When defined, an empty buffer forwards an incoming word combinationally
//   to the output when the instruction fits in that word (zero-cycle latency).
//   When undefined, outputs depend only on registered state and clear_i, and
//   the minimum latency is one cycle.
//
// Handshakes:
//   Both sides use strict valid/ready. A transfer happens in a cycle where
//   valid and ready are both high. in_ready_o depends only on the registered
//   word count. out_valid_o never depends on out_ready_i, and while
//   out_valid_o is high and out_ready_i is low the presented instruction,
//   address and error flag stay stable until taken or until clear_i.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            flush storage and redirect to clear_addr_i (bit0 ignored)
//   clear_addr_i       redirect PC
//   in_valid_i         fetch word valid
//   in_ready_o         buffer can accept a word (count < DEPTH)
//   in_rdata_i         fetch word
//   in_err_i           bus error on this fetch word
//   out_valid_o        instruction available
//   out_ready_i        consumer takes the instruction
//   out_rdata_o        instruction bits (compressed ones are not expanded)
//   out_addr_o         PC of the instruction
//   out_err_o          fetch error affects the instruction
//   out_err_plus2_o    error lies only in the second word of a straddler
// ---------------------------------------------------------------------------
module ibex_instr_realigner #(
    parameter int unsigned DEPTH = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Storage: circular buffer, rd_ptr addresses the oldest word (w0).
    logic [31:0]      mem_data [DEPTH];
    logic [DEPTH-1:0] mem_err;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_next1;
    logic [CNT_W-1:0] count;
    logic [31:0]      pc;

    // Views of the two oldest words after optional bypass.
    logic [31:0] w0_data;
    logic        w0_err;
    logic [31:0] w1_data;
    logic        w1_err;
    logic        have1;
    logic        have2;
    logic        store_skip;

    // Instruction selection.
    logic        sel_valid;
    logic [31:0] sel_rdata;
    logic        sel_err;
    logic        sel_plus2;
    logic        sel_compressed;

    logic        push_req;
    logic        pop_instr;
    logic        pop_word;
    logic        wr_en;
    logic        rd_adv;
    logic [31:0] pc_next;
    logic        unused_clear_lsb;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign unused_clear_lsb = clear_addr_i[0];

    assign in_ready_o   = (count < DEPTH_C);
    assign push_req     = in_valid_i & in_ready_o & ~clear_i;
    assign rd_ptr_next1 = ptr_inc(rd_ptr);

`ifdef IBEX_REALIGN_BYPASS_EN
    // An incoming word stands in for w0 while storage is empty. Straddlers
    // still need a second word (have2), so only fitting instructions pass.
    logic bypass;
    assign bypass  = (count == '0) & push_req;
    assign w0_data = bypass ? in_rdata_i : mem_data[rd_ptr];
    assign w0_err  = bypass ? in_err_i   : mem_err[rd_ptr];
    assign have1   = (count != '0) | bypass;
    // A bypassed word that is fully consumed in the same cycle is not kept.
    assign store_skip = bypass & pop_word;
`else
    assign w0_data    = mem_data[rd_ptr];
    assign w0_err     = mem_err[rd_ptr];
    assign have1      = (count != '0);
    assign store_skip = 1'b0;
`endif

    assign w1_data = mem_data[rd_ptr_next1];
    assign w1_err  = mem_err[rd_ptr_next1];
    assign have2   = (count >= CNT_W'(2));

    always_comb begin
        sel_valid      = 1'b0;
        sel_rdata      = w0_data;
        sel_err        = w0_err;
        sel_plus2      = 1'b0;
        sel_compressed = 1'b0;
        if (!pc[1]) begin
            // Aligned: the whole instruction lives in w0, passed unmodified.
            sel_valid      = have1;
            sel_compressed = (w0_data[1:0] != 2'b11);
        end else if (w0_data[17:16] != 2'b11) begin
            // Compressed instruction in the upper half of w0.
            sel_valid      = have1;
            sel_rdata      = {16'h0000, w0_data[31:16]};
            sel_compressed = 1'b1;
        end else begin
            // Straddling 32-bit instruction. A faulting first word already
            // decides the outcome, so the second word is not waited for.
            sel_rdata = {w1_data[15:0], w0_data[31:16]};
            if (w0_err) begin
                sel_valid = have1;
                sel_err   = 1'b1;
            end else begin
                sel_valid = have2;
                sel_err   = w1_err;
                sel_plus2 = w1_err;
            end
        end
    end

    assign out_valid_o     = sel_valid & ~clear_i;
    assign out_rdata_o     = out_valid_o ? sel_rdata : 32'h0;
    assign out_err_o       = out_valid_o & sel_err;
    assign out_err_plus2_o = out_valid_o & sel_plus2;
    assign out_addr_o      = pc;

    // The new PC crosses a word boundary for any upper-half instruction and
    // for an aligned 32-bit one; exactly one word leaves the FIFO then.
    assign pop_instr = out_valid_o & out_ready_i;
    assign pop_word  = pop_instr & (pc[1] | ~sel_compressed);
    assign pc_next   = pc + (sel_compressed ? 32'd2 : 32'd4);

    assign wr_en  = push_req & ~store_skip;
    assign rd_adv = pop_word & ~store_skip;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pc      <= 32'h0;
            mem_err <= '0;
        end else if (clear_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= {clear_addr_i[31:1], 1'b0};
        end else begin
            if (wr_en) begin
                wr_ptr          <= ptr_inc(wr_ptr);
                mem_err[wr_ptr] <= in_err_i;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr_next1;
            end
            if (wr_en && !rd_adv) begin
                count <= count + CNT_W'(1);
            end else if (!wr_en && rd_adv) begin
                count <= count - CNT_W'(1);
            end
            if (pop_instr) begin
                pc <= pc_next;
            end
        end
    end

    // Word payload needs no reset: it is only observed once count covers it.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= in_rdata_i;
        end
    end

endmodule

// File: tb/tb_ibex_instr_realigner.sv
// ---------------------------------------------------------------------------
// tb_ibex_instr_realigner
//
// Bench for ibex_instr_realigner (default build, DEPTH = 3). The reference
// model treats the buffered instruction stream as a queue of halfwords, each
// tagged with the error flag of the word it came from, plus a PC. Directed
// scenarios come first, followed by randomized traffic with clears and one
// mid-run asynchronous reset.
// ---------------------------------------------------------------------------
module tb_ibex_instr_realigner;

    localparam int unsigned DEPTH = 3;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [31:0] clear_addr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rdata;
    logic        in_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic [31:0] out_addr;
    logic        out_err;
    logic        out_err_plus2;

    int checks = 0;
    int errors = 0;

    ibex_instr_realigner #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clear),
        .clear_addr_i    (clear_addr),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_rdata_i      (in_rdata),
        .in_err_i        (in_err),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_rdata_o     (out_rdata),
        .out_addr_o      (out_addr),
        .out_err_o       (out_err),
        .out_err_plus2_o (out_err_plus2)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each entry: {err, halfword}. hq[0] is the halfword at m_pc.
    logic [16:0] hq[$];
    logic [31:0] m_pc;

    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_plus2;
    logic        e_compressed;
    logic        e_low_only;

    task automatic model_reset();
        hq.delete();
        m_pc = 32'h0;
    endtask

    task automatic model_outputs(input logic clr);
        logic [16:0] h0;
        logic [16:0] h1;
        e_valid      = 1'b0;
        e_rdata      = 32'h0;
        e_err        = 1'b0;
        e_plus2      = 1'b0;
        e_compressed = 1'b0;
        e_low_only   = 1'b0;
        // Words still occupied = halfwords left plus the skipped/consumed lower half.
        e_ready = ((hq.size() + int'(m_pc[1])) / 2) < DEPTH;
        if (hq.size() > 0) begin
            h0 = hq[0];
            h1 = (hq.size() > 1) ? hq[1] : 17'h0;
            e_compressed = (h0[1:0] != 2'b11);
            if (!m_pc[1]) begin
                e_valid = 1'b1;
                e_rdata = {h1[15:0], h0[15:0]};
                e_err   = h0[16];
            end else if (e_compressed) begin
                e_valid = 1'b1;
                e_rdata = {16'h0, h0[15:0]};
                e_err   = h0[16];
            end else if (hq.size() > 1) begin
                e_valid = 1'b1;
                e_rdata = {h1[15:0], h0[15:0]};
                e_err   = h0[16] | h1[16];
                e_plus2 = !h0[16] && h1[16];
            end else if (h0[16]) begin
                e_valid    = 1'b1;
                e_rdata    = {16'h0, h0[15:0]};
                e_err      = 1'b1;
                e_low_only = 1'b1;
            end
        end
        if (clr) e_valid = 1'b0;
    endtask

    task automatic model_update(input logic iv, input logic [31:0] id, input logic ie,
                                input logic ordy, input logic clr, input logic [31:0] ca);
        if (clr) begin
            hq.delete();
            m_pc = {ca[31:1], 1'b0};
        end else begin
            if (e_valid && ordy) begin
                for (int k = 0; k < (e_compressed ? 1 : 2); k++) begin
                    if (hq.size() > 0) void'(hq.pop_front());
                end
                m_pc = m_pc + (e_compressed ? 32'd2 : 32'd4);
            end
            if (iv && e_ready) begin
                if (hq.size() == 0 && m_pc[1]) begin
                    hq.push_back({ie, id[31:16]});
                end else begin
                    hq.push_back({ie, id[15:0]});
                    hq.push_back({ie, id[31:16]});
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs, compares DUT against the model mid-cycle,
    // advances the model, and returns just after the clock edge with idle inputs.
    task automatic run_cycle(input logic iv, input logic [31:0] id, input logic ie,
                             input logic ordy, input logic clr, input logic [31:0] ca);
        in_valid   = iv;
        in_rdata   = id;
        in_err     = ie;
        out_ready  = ordy;
        clear      = clr;
        clear_addr = ca;
        @(negedge clk);
        model_outputs(clr);
        check_eq("in_ready", {31'h0, in_ready}, {31'h0, e_ready});
        check_eq("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
        check_eq("out_addr", out_addr, m_pc);
        if (e_valid) begin
            if (e_low_only) check_eq("out_rdata_lo", {16'h0, out_rdata[15:0]}, e_rdata);
            else            check_eq("out_rdata", out_rdata, e_rdata);
            check_eq("out_err", {31'h0, out_err}, {31'h0, e_err});
            check_eq("out_err_plus2", {31'h0, out_err_plus2}, {31'h0, e_plus2});
        end
        model_update(iv, id, ie, ordy, clr, ca);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic e);
        run_cycle(1'b1, d, e, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pop_one();
        run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] a);
        run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, a);
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else                           h[1:0] = 2'($urandom_range(0, 2));
        return h;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        clear_addr = 32'h0;
        in_valid   = 1'b0;
        in_rdata   = 32'h0;
        in_err     = 1'b0;
        out_ready  = 1'b0;
        model_reset();

        // Reset values.
        #2;
        check_eq("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check_eq("rst_out_addr", out_addr, 32'h0);
        check_eq("rst_out_rdata", out_rdata, 32'h0);
        check_eq("rst_out_err", {31'h0, out_err}, 32'h0);
        check_eq("rst_out_plus2", {31'h0, out_err_plus2}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Aligned 32-bit instruction.
        redirect(32'h100);
        push_word(32'h00130513, 1'b0);
        check_eq("tp1_valid", {31'h0, out_valid}, 32'h1);
        check_eq("tp1_rdata", out_rdata, 32'h00130513);
        check_eq("tp1_addr", out_addr, 32'h100);
        pop_one();
        check_eq("tp1_empty_valid", {31'h0, out_valid}, 32'h0);
        check_eq("tp1_next_addr", out_addr, 32'h104);

        // Odd redirect, compressed upper half.
        redirect(32'h103);
        push_word(32'h45050001, 1'b0);
        push_word(32'h00000000, 1'b0);
        check_eq("tp2_rdata", out_rdata, 32'h00004505);
        check_eq("tp2_addr", out_addr, 32'h102);
        pop_one();
        check_eq("tp2_next_addr", out_addr, 32'h104);
        check_eq("tp2_next_rdata", out_rdata, 32'h00000000);
        check_eq("tp2_next_valid", {31'h0, out_valid}, 32'h1);

        // Straddling 32-bit instruction.
        redirect(32'h102);
        push_word(32'h05130001, 1'b0);
        check_eq("tp3_wait_valid", {31'h0, out_valid}, 32'h0);
        push_word(32'h00000013, 1'b0);
        check_eq("tp3_rdata", out_rdata, 32'h00130513);
        check_eq("tp3_addr", out_addr, 32'h102);
        pop_one();
        check_eq("tp3_next_addr", out_addr, 32'h106);
        check_eq("tp3_next_valid", {31'h0, out_valid}, 32'h1);

        // Straddle with error on the second word, then on the first.
        redirect(32'h102);
        push_word(32'h05130001, 1'b0);
        push_word(32'h00000013, 1'b1);
        check_eq("tp4_err", {31'h0, out_err}, 32'h1);
        check_eq("tp4_plus2", {31'h0, out_err_plus2}, 32'h1);
        redirect(32'h102);
        push_word(32'h05130001, 1'b1);
        check_eq("tp4b_valid", {31'h0, out_valid}, 32'h1);
        check_eq("tp4b_err", {31'h0, out_err}, 32'h1);
        check_eq("tp4b_plus2", {31'h0, out_err_plus2}, 32'h0);
        pop_one();

        // Fill to DEPTH with the consumer stalled.
        redirect(32'h100);
        for (int i = 0; i < DEPTH; i++) push_word(32'h00130513, 1'b0);
        check_eq("tp5_full_ready", {31'h0, in_ready}, 32'h0);
        run_cycle(1'b1, 32'hdeadbeef, 1'b0, 1'b0, 1'b0, 32'h0);
        pop_one();
        check_eq("tp5_ready_again", {31'h0, in_ready}, 32'h1);
        push_word(32'h00130513, 1'b0);
        check_eq("tp5_refull_ready", {31'h0, in_ready}, 32'h0);

        // Clear beats a simultaneous push and pop.
        run_cycle(1'b1, 32'h11111111, 1'b0, 1'b1, 1'b1, 32'h201);
        check_eq("tp6_valid", {31'h0, out_valid}, 32'h0);
        check_eq("tp6_addr", out_addr, 32'h200);
        check_eq("tp6_ready", {31'h0, in_ready}, 32'h1);

        // Randomized traffic.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic        iv;
            logic        ordy;
            logic        clr;
            logic        ie;
            logic [31:0] d;
            logic [31:0] ca;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ((cyc / 200) % 3 == 1) ? ($urandom_range(0, 9) < 2)
                                          : ($urandom_range(0, 9) < 6);
            clr  = ($urandom_range(0, 39) == 0);
            ie   = ($urandom_range(0, 15) == 0);
            d    = {rand_half(), rand_half()};
            ca   = $urandom;
            run_cycle(iv, d, ie, ordy, clr, ca);

            if (cyc == 2500) begin
                // Asynchronous reset in the middle of traffic.
                in_valid  = 1'b1;
                out_ready = 1'b1;
                #2;
                rst_n = 1'b0;
                #1;
                check_eq("arst_valid", {31'h0, out_valid}, 32'h0);
                check_eq("arst_addr", out_addr, 32'h0);
                check_eq("arst_ready", {31'h0, in_ready}, 32'h1);
                in_valid  = 1'b0;
                out_ready = 1'b0;
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_instr_realigner.md
Name: ibex_instr_realigner

Overview:
- Instruction realignment buffer between the instruction-memory fetch interface and the compressed decoder.
- Accepts 32-bit aligned fetch words and buffers them.
- Presents one instruction per handshake, either 16-bit compressed or 32-bit (possibly straddling two words), with its PC.
- The downstream decoder tests bits [1:0] and expands compressed instructions.
- Flushed on branch/jump redirect with a new halfword-aligned address.

Parameters:
- DEPTH, 3, number of 32-bit word entries held (legal range 2..8).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  flush storage and redirect
- clear_addr_i  in  32  redirect PC; bit0 ignored
- in_valid_i  in  1  fetch word valid
- in_ready_o  out  1  buffer can accept a word
- in_rdata_i  in  32  fetch word, word-aligned
- in_err_i  in  1  bus error on this word
- out_valid_o  out  1  instruction available
- out_ready_i  in  1  consumer takes instruction
- out_rdata_o  out  32  instruction bits
- out_addr_o  out  32  PC of instruction
- out_err_o  out  1  fetch error affects instruction
- out_err_plus2_o  out  1  error lies only in second word of a straddling instruction

Behaviour:
- Clock/reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values:
  - entry count 0; all err bits 0
  - PC register 0, so out_addr_o = 0
  - out_valid_o 0, out_err_o 0, out_err_plus2_o 0, out_rdata_o 0
  - in_ready_o 1
- Storage: FIFO of DEPTH {rdata, err} entries; w0 = oldest, w1 = next.
- PC register: out_addr_o; bit1 = halfword offset within w0; bit0 always 0.
- in_ready_o = (count < DEPTH). Purely from registered count, with no combinational path from out_ready_i.
- Push: in_valid_i && in_ready_o && !clear_i. Word written at tail.
- Output selection, PC[1] = 0:
  - needs count >= 1
  - out_rdata_o = w0
  - out_err_o = w0.err
- Output selection, PC[1] = 1, w0[17:16] != 2'b11 (compressed):
  - needs count >= 1
  - out_rdata_o = {16'h0000, w0[31:16]}
- Output selection, PC[1] = 1, w0[17:16] == 2'b11 (straddling):
  - needs count >= 2
  - out_rdata_o = {w1[15:0], w0[31:16]}
  - out_err_o = w0.err | w1.err
  - out_err_plus2_o = !w0.err & w1.err
  - Exception: if w0.err = 1, valid with count >= 1 and out_err_o = 1, since the second word is not needed.
- Aligned compressed (PC[1] = 0, w0[1:0] != 2'b11): out_rdata_o = w0 unmodified. The decoder uses [15:0].
- out_err_plus2_o = 0 in every case except straddling.
- Pop, on out_valid_o && out_ready_i:
  - PC advances by 2 if the presented instruction is compressed, else by 4; 32-bit wrap-around.
  - w0 is popped when the new PC crosses a word boundary.
  - Straddling consumption pops exactly one word: w1 becomes w0 with PC[1] = 1.
- Simultaneous push and pop in one cycle: count unchanged. Legal only when count < DEPTH at cycle start.
- clear_i, highest priority:
  - next cycle count = 0 and PC = {clear_addr_i[31:1], 1'b0}
  - any same-cycle push is discarded
  - out_valid_o is forced 0 in the clear cycle; a same-cycle out_ready_i is ignored
- Redirect to an odd halfword: the first fetched word's lower half is skipped via PC[1] = 1.
- Latency: a word pushed in cycle N produces out_valid_o at N+1 at the earliest.
- Output stability: with out_valid_o = 1 and out_ready_i = 0, out_rdata_o, out_addr_o and out_err_o hold stable until consumption or clear_i.
- Unconsumed upper halfword when storage is full: retained; no word is dropped.
- Reset mid-operation: all state returns to reset values immediately, asynchronously.

Optional Feature:
- Macro: IBEX_REALIGN_BYPASS_EN.
- Defined:
  - When count = 0 and a push occurs, out_valid_o is asserted in the same cycle with in_rdata_i/in_err_i as w0, for zero-cycle latency.
  - This applies only if the instruction fits in that word (not straddling, unless in_err_i = 1).
  - If consumed the same cycle, the word is written only if its upper compressed half remains unconsumed; otherwise it is not stored.
- Undefined: no combinational in-to-out path; minimum latency is 1 cycle.
- in_ready_o behaviour is identical in both builds.

Test Plan:
- Reset, clear_addr 0x100, push 0x00130513:
  - out_valid next cycle, rdata 0x00130513, addr 0x100
  - pop -> count 0
- Clear to 0x102, push 0x4505_0001 then 0x0000_0000:
  - first output rdata 0x00004505, addr 0x102, compressed, pops w0
  - next output from second word at 0x104
- Clear to 0x102:
  - push 0x0513_0001 -> no valid yet (straddling needs two words)
  - push 0x0000_0013 -> rdata 0x00130513, addr 0x102
  - after pop, PC 0x106, count 1
- Straddle at 0x102 with second word in_err_i = 1:
  - out_err_o = 1, out_err_plus2_o = 1
  - with first word err instead: valid after one word, err 1, plus2 0
- Fill DEPTH = 3 words with out_ready_i = 0:
  - in_ready_o drops to 0 after third push
  - one pop of a 32-bit instruction raises in_ready_o next cycle
- Assert clear_i with count 3, out_ready_i = 1 and in_valid_i = 1:
  - no pop/push counted; next cycle count 0, out_valid 0, addr = clear_addr_i
